// File: rtl/inst_mem_loader.sv
// Program loader: takes a byte stream (32-bit LE word count, then LE words) and writes
// consecutive instruction-memory words from address 0, holding the core while loading.
module inst_mem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept_c;
    logic [31:0]       full_word_c;

    assign accept_c    = byte_valid && byte_ready_q;
    assign full_word_c = {byte_data, asm_q};

    // Next-state, byte assembly and registered-output decode
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        idx_d     = idx_q;
        n_d       = n_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_HEADER;
                    bcnt_d  = 2'd0;
                    idx_d   = '0;
                    n_d     = '0;
                    asm_d   = '0;
                end
            end
            S_HEADER, S_DATA: begin
                if (accept_c) begin
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        2'd3: begin
                            if (state_q == S_HEADER) begin
                                if (full_word_c == 32'd0) begin
                                    state_d = S_DONE;
                                end else if ({1'b0, full_word_c} > (33'd1 << ADDR_W)) begin
                                    state_d = S_ERROR;
                                end else begin
                                    n_d     = IDX_W'(full_word_c);
                                    state_d = S_DATA;
                                end
                            end else begin
                                wr_data_d = full_word_c;
                                wr_addr_d = 32'({idx_q[ADDR_W-1:0], 2'b00});
                                state_d   = S_WRITE;
                            end
                        end
                    endcase
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q + IDX_W'(1) == n_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_HEADER) || (state_d == S_DATA);
        wr_en_d      = (state_d == S_WRITE);
        core_hold_d  = (state_d == S_HEADER) || (state_d == S_DATA) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bcnt_q       <= 2'd0;
            asm_q        <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            core_hold_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            core_hold_q  <= core_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: one instance at ADDR_W=10, one at ADDR_W=4,
// driven through a shared byte source selected by sel.
module tb_inst_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    bit         sel;

    logic        a_rdy, a_we, a_hold, a_done, a_err;
    logic [31:0] a_addr, a_data;
    logic        b_rdy, b_we, b_hold, b_done, b_err;
    logic [31:0] b_addr, b_data;

    inst_mem_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .start(start && !sel), .byte_valid(byte_valid && !sel), .byte_data(byte_data),
        .byte_ready(a_rdy), .wr_en(a_we), .wr_addr(a_addr), .wr_data(a_data),
        .core_hold(a_hold), .done(a_done), .error(a_err)
    );

    inst_mem_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .start(start && sel), .byte_valid(byte_valid && sel), .byte_data(byte_data),
        .byte_ready(b_rdy), .wr_en(b_we), .wr_addr(b_addr), .wr_data(b_data),
        .core_hold(b_hold), .done(b_done), .error(b_err)
    );

    logic        rdy, we, hold, dn, er;
    logic [31:0] addr, data;
    always_comb begin
        rdy  = sel ? b_rdy  : a_rdy;
        we   = sel ? b_we   : a_we;
        hold = sel ? b_hold : a_hold;
        dn   = sel ? b_done : a_done;
        er   = sel ? b_err  : a_err;
        addr = sel ? b_addr : a_addr;
        data = sel ? b_data : a_data;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Capture every write; the loader must never offer ready during a write cycle
    always @(negedge clk) begin
        if (!rst && we) begin
            check("ready_in_write", 32'(rdy), 32'd0);
            wa.push_back(addr);
            wd.push_back(data);
        end
    end

    // Called right after a negedge; returns right after the negedge following acceptance
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) begin
            int g;
            g = int'($urandom_range(0, 2));
            byte_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rdy) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic pulse_start();
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_nominal(input bit gaps);
        wa.delete();
        wd.delete();
        pulse_start();
        check("start_ready", 32'(rdy), 32'd1);
        check("start_hold", 32'(hold), 32'd1);
        send_word(32'd2, gaps);
        send_word(32'h0010_0513, gaps);
        check("wr_latency0", 32'(we), 32'd1);
        if (gaps) pulse_start();
        send_word(32'h0000_006F, gaps);
        check("wr_latency1", 32'(we), 32'd1);
        byte_valid = 1'b0;
        @(negedge clk);
        check("nom_done", 32'(dn), 32'd1);
        check("nom_hold", 32'(hold), 32'd0);
        check("nom_error", 32'(er), 32'd0);
        repeat (2) @(negedge clk);
        check("nom_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("nom_addr0", wa[0], 32'h0);
            check("nom_data0", wd[0], 32'h0010_0513);
            check("nom_addr1", wa[1], 32'h4);
            check("nom_data1", wd[1], 32'h0000_006F);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", 32'({rdy, we, hold, dn, er}), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_data", data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_nominal(1'b0);

        // Zero word count
        wa.delete();
        pulse_start();
        send_word(32'd0, 1'b0);
        byte_valid = 1'b0;
        check("zero_done", 32'(dn), 32'd1);
        check("zero_hold", 32'(hold), 32'd0);
        repeat (2) @(negedge clk);
        check("zero_nwrites", 32'(wa.size()), 32'd0);

        // Oversize count on the 1024-word instance
        wa.delete();
        pulse_start();
        send_word(32'd1025, 1'b0);
        byte_valid = 1'b0;
        check("ovr_error", 32'(er), 32'd1);
        check("ovr_hold", 32'(hold), 32'd0);
        check("ovr_ready", 32'(rdy), 32'd0);
        check("ovr_done", 32'(dn), 32'd0);
        repeat (2) @(negedge clk);
        check("ovr_nwrites", 32'(wa.size()), 32'd0);

        run_nominal(1'b0);
        check("ovr_cleared", 32'(er), 32'd0);

        // Gaps on the source plus a start issued mid-load
        for (int r = 0; r < 3; r++) run_nominal(1'b1);

        // Full depth on the 16-word instance, then one word too many
        sel = 1'b1;
        @(negedge clk);
        wa.delete();
        wd.delete();
        pulse_start();
        send_word(32'd16, 1'b0);
        for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 | 32'(i * 3), 1'b0);
        byte_valid = 1'b0;
        @(negedge clk);
        check("full_done", 32'(dn), 32'd1);
        check("full_nwrites", 32'(wa.size()), 32'd16);
        if (wa.size() == 16) begin
            check("full_last_addr", wa[15], 32'h3C);
            for (int i = 0; i < 16; i++) begin
                check("full_addr", wa[i], 32'(i * 4));
                check("full_data", wd[i], 32'hC0DE_0000 | 32'(i * 3));
            end
        end
        pulse_start();
        send_word(32'd17, 1'b0);
        byte_valid = 1'b0;
        check("full_ovr_error", 32'(er), 32'd1);
        check("full_ovr_hold", 32'(hold), 32'd0);

        // Reset in the middle of the second word
        sel = 1'b0;
        @(negedge clk);
        wa.delete();
        wd.delete();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_flags", 32'({rdy, we, hold, dn, er}), 32'd0);
        check("mid_rst_addr", addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_idle", 32'({rdy, hold, dn, er}), 32'd0);
        check("mid_rst_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) check("mid_rst_data0", wd[0], 32'h1122_3344);

        run_nominal(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Program loader that fills instruction memory before the core runs, as the write-side counterpart to the fetch-stage read port. It accepts a byte stream through a valid/ready handshake, reads a 32-bit word-count header, and assembles little-endian 32-bit instruction words. Each completed word is written to sequential word-aligned addresses starting at 0. While loading, it holds the core (PC/fetch) in reset-hold via `core_hold`.

## Interface
- `ADDR_W`, default 10: instruction memory depth is 2^ADDR_W words; must match the memory's size width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle load request; ignored while a load is in progress.
- `byte_valid`  in  1  stream byte present.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts `byte_data` this cycle. A transfer occurs when `byte_valid && byte_ready`.
- `wr_en`  out  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  out  32  byte address of the write; always a multiple of 4.
- `wr_data`  out  32  assembled instruction word.
- `core_hold`  out  1  high while loading; fetch must not advance.
- `done`  out  1  sticky; last load completed successfully.
- `error`  out  1  sticky; last load rejected (count too large).

## Operation
- States: IDLE, HEADER, DATA, WRITE, DONE, ERROR.
- **IDLE / DONE / ERROR**
  - `start` moves the loader to HEADER.
  - On that transition: clear `done`, `error`, the byte counter (0..3), the word address, and the word count.
- **HEADER**
  - `byte_ready`=1.
  - Accept 4 bytes into N, little-endian: first byte goes to N[7:0].
  - After the 4th byte:
    - N == 0 → DONE.
    - N > 2^ADDR_W → ERROR.
    - Otherwise → DATA.
- **DATA**
  - `byte_ready`=1.
  - Byte k (0..3) of the current word goes to `wr_data[8k+7:8k]`.
  - The 4th byte moves the loader to WRITE.
- **WRITE**
  - `byte_ready`=0, `wr_en`=1 for exactly one cycle, with `wr_addr` = 4 × word index.
  - Then increment the word index.
  - If the index equals N → DONE, else → DATA.
- **Outputs by state**
  - `core_hold`=1 in HEADER, DATA and WRITE; 0 in IDLE, DONE and ERROR.
  - `done`=1 only in DONE; `error`=1 only in ERROR.
- Bytes offered while `byte_ready`=0 are not consumed; the source must hold them.
- `wr_data` and `wr_addr` hold their last values when `wr_en`=0. The memory is only required to sample them when `wr_en`=1.
- The word index is ADDR_W+1 bits wide. `wr_addr` = {index[ADDR_W-1:0], 2'b00}, zero-extended to 32 bits. The address never wraps, because N ≤ 2^ADDR_W is checked.
- A `start` in HEADER, DATA or WRITE is ignored.

## Timing
- **Reset values** (asynchronous, immediate): state IDLE, and `byte_ready`, `wr_en`, `core_hold`, `done`, `error` all 0. `wr_addr` and `wr_data` are 0.
- **Reset mid-load:** outputs return to the reset values at once. Words already written stay in memory. No further writes occur.
- **Start:** `start` sampled at edge t → HEADER from t+1, with `byte_ready` and `core_hold` high in cycle t+1.
- **Streaming rate:** one byte per cycle when `byte_valid` is held high.
- **Word latency:** a word's 4th byte is accepted at edge t → `wr_en`=1 during cycle t+1 (WRITE). The next byte is accepted no earlier than edge t+2. Sustained throughput is 4 bytes per 5 cycles.
- **Stalls:** gaps in `byte_valid` stall the FSM indefinitely with no timeout. State and partial word are kept.
- **Final write:** the last write cycle is followed by DONE on the next edge. `core_hold` falls and `done` rises together.

## Test plan
- **Nominal load.**
  - Stimulus: `start`, then bytes 02 00 00 00, 13 05 10 00, 6F 00 00 00.
  - Required: writes (addr 0x0, data 0x00100513) then (addr 0x4, data 0x0000006F); then `done`=1 and `core_hold`=0. Exactly 2 `wr_en` pulses.
- **Zero count.**
  - Stimulus: header 00 00 00 00.
  - Required: DONE on the edge after the 4th byte, with no `wr_en`.
- **Oversize count.**
  - Stimulus: ADDR_W=10, header 01 04 00 00 (N=1025).
  - Required: `error`=1, `core_hold`=0, `byte_ready`=0, no writes.
  - Then `start` with a valid load succeeds and clears `error`.
- **Backpressure and gaps.**
  - Stimulus: toggle `byte_valid` randomly during the nominal load.
  - Required: identical writes. `byte_ready` is low in every WRITE cycle and no byte is dropped or duplicated.
- **Full depth.**
  - Stimulus: ADDR_W=4, N=16 words.
  - Required: last write at addr 0x3C, then DONE.
- **Reset mid-word.**
  - Stimulus: assert `rst` after 2 data bytes of word 1.
  - Required: immediate IDLE with all flags 0. `start` ignored during a load does not restart the header.
